// File: rtl/csum_array_pkg.sv
// csum_array_pkg: shared definitions for the multi-lane group summer.
//   Default widths, the shift-amount width and the controller state encoding.
package csum_array_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;
  localparam int SHIFT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/csum_array_lane.sv
// csum_lane: one lane of csum_array.
//   Holds an ACC_W signed accumulator (wide enough that 2^CNT_W-1 words cannot
//   overflow it). The accumulator can be cleared or can add one sign-extended
//   word. The result is optionally arithmetic-right-shifted, which rounds
//   toward minus infinity, and is then clamped to the DATA_W signed range.
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        zero the accumulator
//   en         add din to the accumulator
//   din        signed input word
//   avg/shift  when avg is set, the result is acc >>> shift
//   dout/sat   clamped result and a flag that the clamp was applied
module csum_lane
  import csum_array_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DATA_W-1:0]  din,
  input  logic               avg,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  dout,
  output logic               sat
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + {{(ACC_W-DATA_W){din[DATA_W-1]}}, din};
  end

  always_comb begin
    res  = avg ? (acc >>> shift) : acc;
    sat  = 1'b0;
    dout = res[DATA_W-1:0];
    if (res > MAX_V) begin
      sat  = 1'b1;
      dout = MAX_V[DATA_W-1:0];
    end else if (res < MIN_V) begin
      sat  = 1'b1;
      dout = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/csum_array.sv
// csum_array: sums cfg_len consecutive FIFO word-vectors on N_CH independent
// lanes and presents one saturated result per lane, which can optionally be
// averaged by a power-of-two shift.
// Ports:
//   clk, rst            clock, async active-high reset
//   fifo_empty, rd_en   input FIFO status and read strobe (one vector per rd_en)
//   rd_data, rd_valid   FIFO read return, any fixed latency >= 1
//   cfg_len/avg/shift   group configuration, captured when a group starts
//   out_data, out_sat   per-lane result and clamp flags, valid in OUT only
//   out_valid/out_ready result handshake; the result is held until accepted
//   busy                a group is in progress
//
// state   | meaning
// IDLE    | waiting for data (or a zero-length group); clears the lanes
// ACC     | issuing reads and accumulating returned words
// OUT     | result presented, waiting for out_ready
module csum_array
  import csum_array_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   rd_en,
  input  logic [N_CH*DATA_W-1:0] rd_data,
  input  logic                   rd_valid,
  input  logic [CNT_W-1:0]       cfg_len,
  input  logic                   cfg_avg,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     len_q, issued, recvd, recvd_nx;
  logic                 avg_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 acc_fire;
  logic [N_CH*DATA_W-1:0] lane_data;
  logic [N_CH-1:0]      lane_sat;

  // Reads are gated by the live fifo_empty so that rd_en is never high while
  // the FIFO is empty. Returns are only counted up to len, so a stray
  // rd_valid cannot push recvd beyond the group.
  assign rd_en    = (state == ST_ACC) && !fifo_empty && (issued < len_q);
  assign acc_fire = (state == ST_ACC) && rd_valid && (recvd < len_q);
  assign recvd_nx = recvd + CNT_W'(acc_fire);
  assign busy     = (state != ST_IDLE);
  assign out_valid = (state == ST_OUT);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (!fifo_empty || (cfg_len == '0)) state_nx = ST_ACC;
      // Leave on the same cycle as the last return; the lane adds it at this edge.
      ST_ACC:  if (recvd_nx == len_q) state_nx = ST_OUT;
      ST_OUT:  if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      avg_q   <= 1'b0;
      shift_q <= '0;
      issued  <= '0;
      recvd   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          issued <= '0;
          recvd  <= '0;
          if (state_nx == ST_ACC) begin
            len_q   <= cfg_len;
            avg_q   <= cfg_avg;
            shift_q <= cfg_shift;
          end
        end
        ST_ACC: begin
          issued <= issued + CNT_W'(rd_en);
          recvd  <= recvd_nx;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_lane
      csum_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_IDLE),
        .en    (acc_fire),
        .din   (rd_data[gi*DATA_W +: DATA_W]),
        .avg   (avg_q),
        .shift (shift_q),
        .dout  (lane_data[gi*DATA_W +: DATA_W]),
        .sat   (lane_sat[gi])
      );
    end
  endgenerate

  // The accumulators and configuration are frozen in OUT, so the lane results
  // are stable there; outside OUT the outputs read as zero.
  always_comb begin
    out_data = '0;
    out_sat  = '0;
    if (state == ST_OUT) begin
      out_data = lane_data;
      out_sat  = lane_sat;
    end
  end

endmodule

// File: tb/tb_csum_array.sv
// tb_csum_array: directed bench for csum_array with two 16-bit lanes.
//   A behavioural FIFO with 1-cycle read latency feeds the DUT. Table vectors
//   cover sums, averaging and saturation, and hand sequences cover FIFO stalls,
//   backpressure, zero-length groups and reset in the middle of a group.
module tb_csum_array;

  localparam int N_CH   = 2;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty = 1'b1;
  logic              rd_en;
  logic [31:0]       rd_data = '0;
  logic              rd_valid = 1'b0;
  logic [CNT_W-1:0]  cfg_len;
  logic              cfg_avg;
  logic [3:0]        cfg_shift;
  logic [31:0]       out_data;
  logic [1:0]        out_sat;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  csum_array #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .cfg_len(cfg_len),
    .cfg_avg(cfg_avg), .cfg_shift(cfg_shift), .out_data(out_data),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: rd_en is sampled between edges; the popped word is returned
  // with rd_valid on the following cycle.
  logic [31:0] q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  bit          toggle_en = 1'b0;
  logic        force_empty = 1'b0;
  int          rd_cnt = 0;
  int          viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      pend     = 1'b0;
      rd_valid = 1'b0;
      rd_data  = '0;
    end else begin
      rd_valid = pend;
      rd_data  = pend_data;
      pend     = 1'b0;
    end
    if (toggle_en) force_empty = ~force_empty;
    else           force_empty = 1'b0;
    fifo_empty = (q.size() == 0) || force_empty;
    #1;
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (fifo_empty) viol++;
      if (q.size() > 0) pend_data = q.pop_front();
      else              pend_data = '0;
      pend = 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int              len;
    bit              avg;
    logic [3:0]      shift;
    logic [3:0][15:0] l0;
    logic [3:0][15:0] l1;
    logic [15:0]     e0;
    logic [15:0]     e1;
    logic [1:0]      esat;
  } vec_t;

  function automatic vec_t mk(input int len, input bit avg, input int sh,
                              input logic [15:0] a0, a1, a2, a3,
                              input logic [15:0] b0, b1, b2, b3,
                              input logic [15:0] e0, e1, input logic [1:0] s);
    vec_t v;
    v.len = len; v.avg = avg; v.shift = 4'(sh);
    v.l0[0] = a0; v.l0[1] = a1; v.l0[2] = a2; v.l0[3] = a3;
    v.l1[0] = b0; v.l1[1] = b1; v.l1[2] = b2; v.l1[3] = b3;
    v.e0 = e0; v.e1 = e1; v.esat = s;
    return v;
  endfunction

  task automatic push_vec(input vec_t v);
    cfg_len   = 8'(v.len);
    cfg_avg   = v.avg;
    cfg_shift = v.shift;
    for (int i = 0; i < v.len; i++) q.push_back({v.l1[i], v.l0[i]});
  endtask

  // Waits (bounded) for out_valid; counts cycles spent busy before it.
  task automatic wait_valid(input string name, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #2;
      n++;
      if (busy === 1'b1 && out_valid !== 1'b1) busy_cyc++;
    end
    if (out_valid !== 1'b1) check({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string name, input vec_t v);
    check({name, "_data"}, out_data, {v.e1, v.e0});
    check({name, "_sat"}, 32'(out_sat), 32'(v.esat));
    check({name, "_reads"}, 32'(rd_cnt), 32'(v.len));
  endtask

  vec_t vecs[8];
  vec_t va, vb;
  int   bc;
  logic [31:0] exp_w;

  initial begin
    rst = 1'b1; cfg_len = 8'd4; cfg_avg = 1'b0; cfg_shift = 4'd0; out_ready = 1'b1;

    vecs[0] = mk(4, 0, 0,  16'h0001, 16'h0002, 16'h0003, 16'h0004,
                           16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'h000A, 16'hFFF6, 2'b00);
    vecs[1] = mk(4, 1, 2,  16'h0005, 16'h0005, 16'h0005, 16'h0006,
                           16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'hFFFF, 2'b00);
    vecs[2] = mk(3, 0, 0,  16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000,
                           16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 2'b11);
    vecs[3] = mk(1, 0, 0,  16'h1234, 16'h0000, 16'h0000, 16'h0000,
                           16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h8000, 2'b00);
    vecs[4] = mk(2, 1, 1,  16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000,
                           16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 2'b00);
    vecs[5] = mk(2, 1, 0,  16'h7FFF, 16'h0001, 16'h0000, 16'h0000,
                           16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 2'b11);
    vecs[6] = mk(2, 1, 15, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000,
                           16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0001, 16'hFFFE, 2'b00);
    vecs[7] = mk(3, 1, 1,  16'h0003, 16'h0000, 16'h0000, 16'h0000,
                           16'hFFFD, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'hFFFE, 2'b00);

    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    for (int k = 0; k < 8; k++) begin
      rd_cnt = 0;
      push_vec(vecs[k]);
      wait_valid($sformatf("vec%0d", k), bc);
      check_result($sformatf("vec%0d", k), vecs[k]);
      check($sformatf("vec%0d_latency", k), 32'(bc), 32'(vecs[k].len + 1));
      @(posedge clk); #2;
      check($sformatf("vec%0d_valid_drop", k), 32'(out_valid), 32'd0);
    end

    // FIFO empty every other cycle: reads stall, nothing lost or duplicated.
    rd_cnt = 0; viol = 0; toggle_en = 1'b1;
    cfg_len = 8'd8; cfg_avg = 1'b0; cfg_shift = 4'd0;
    for (int i = 0; i < 8; i++) q.push_back({16'(100 * (i + 1)), 16'(i + 1)});
    wait_valid("stall", bc);
    check("stall_data", out_data, {16'h0E10, 16'h0024});
    check("stall_reads", 32'(rd_cnt), 32'd8);
    check("stall_read_while_empty", 32'(viol), 32'd0);
    toggle_en = 1'b0;
    @(posedge clk); #2;

    // Backpressure: result held, no reads while a second group waits in the FIFO.
    va = mk(2, 0, 0, 16'h0064, 16'hFFCE, 16'h0000, 16'h0000,
                     16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0032, 16'h0007, 2'b00);
    vb = mk(2, 0, 0, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                     16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0004, 2'b00);
    out_ready = 1'b0;
    rd_cnt = 0;
    push_vec(va);
    wait_valid("bp_a", bc);
    check_result("bp_a", va);
    push_vec(vb);
    exp_w = {va.e1, va.e0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, exp_w);
    end
    check("bp_no_reads", 32'(rd_cnt), 32'd2);
    rd_cnt = 0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    wait_valid("bp_b", bc);
    check_result("bp_b", vb);
    @(posedge clk); #2;

    // Zero-length group.
    out_ready = 1'b0;
    rd_cnt = 0;
    cfg_len = 8'd0;
    wait_valid("len0", bc);
    cfg_len = 8'd4;
    check("len0_data", out_data, 32'd0);
    check("len0_sat", 32'(out_sat), 32'd0);
    check("len0_reads", 32'(rd_cnt), 32'd0);
    check("len0_latency", 32'(bc), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("len0_valid_drop", 32'(out_valid), 32'd0);

    // Reset in the middle of a group.
    rd_cnt = 0;
    cfg_len = 8'd8; cfg_avg = 1'b0; cfg_shift = 4'd0;
    for (int i = 0; i < 8; i++) q.push_back({16'h0001, 16'h0001});
    for (int i = 0; i < 50 && rd_cnt < 3; i++) begin
      @(posedge clk); #2;
    end
    check("midrst_reads_started", 32'(rd_cnt >= 3), 32'd1);
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_rd_en", 32'(rd_en), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midrst_idle_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
